// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, forwarding selects and match helper for hazard_ctrl
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    TIMEOUT = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       use1;
    logic       use2;
    logic       regwrite;
    logic       wbsel;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  function automatic logic reg_match(input logic [2:0] x, input stage_t s, input logic r0_zero);
    return s.regwrite && (s.rd == x) && !(r0_zero && (x == 3'd0));
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// rtl/hazard_shadow_pipe.sv - EX/MEM/WB shadow copies of the ID-stage control fields
module hazard_shadow_pipe
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold_i,
  input  logic   bubble_i,
  input  stage_t id_i,
  output stage_t ex_o,
  output stage_t mem_o,
  output stage_t wb_o
);

  stage_t ex_q, mem_q, wb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (!hold_i) begin
      ex_q  <= bubble_i ? BUBBLE : id_i;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward controller; FWD_EN enables EX forwarding
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int R0_ZERO  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs1,
  input  logic [2:0]  id_rs2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [2:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_wbsel,
  input  logic        mem_wait,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] bubble_cnt,
  output logic        err
);

  localparam logic R0Z = (R0_ZERO != 0);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d, wait_inc;
  logic [15:0] bcnt_q, bcnt_d;
  logic        err_q, err_d;
  logic        hold, bubble, pc_en_c, flush_c, hazard;
  stage_t      id_s, ex_s, mem_s, wb_s;
  logic        unused_fields;

  assign id_s = '{rd: id_rd, rs1: id_rs1, rs2: id_rs2, use1: id_use1, use2: id_use2,
                  regwrite: id_regwrite, wbsel: id_wbsel};

  hazard_shadow_pipe u_shadow (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (hold),
    .bubble_i (bubble),
    .id_i     (id_s),
    .ex_o     (ex_s),
    .mem_o    (mem_s),
    .wb_o     (wb_s)
  );

`ifdef FWD_EN
  assign hazard = ex_s.wbsel &&
                  ((id_use1 && reg_match(id_rs1, ex_s, R0Z)) ||
                   (id_use2 && reg_match(id_rs2, ex_s, R0Z)));
`else
  // Without forwarding the consumer waits until the producer has fully retired.
  assign hazard = (id_use1 && (reg_match(id_rs1, ex_s, R0Z) || reg_match(id_rs1, mem_s, R0Z) ||
                               reg_match(id_rs1, wb_s, R0Z))) ||
                  (id_use2 && (reg_match(id_rs2, ex_s, R0Z) || reg_match(id_rs2, mem_s, R0Z) ||
                               reg_match(id_rs2, wb_s, R0Z)));
`endif

  assign wait_inc = wait_q + 8'd1;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    pc_en_c = 1'b0;
    flush_c = 1'b1;
    hold    = 1'b1;
    bubble  = 1'b0;
    case (state_q)
      RUN, WAIT: begin
        if (mem_wait) begin
          flush_c = 1'b0;
          wait_d  = wait_inc;
          if (wait_inc == 8'(MAX_WAIT)) begin
            state_d = TIMEOUT;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = RUN;
          wait_d  = 8'd0;
          hold    = 1'b0;
          if (hazard) begin
            bubble = 1'b1;
            if (bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
          end else begin
            pc_en_c = 1'b1;
            flush_c = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      bcnt_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  assign pc_en      = rst & pc_en_c;
  assign ifid_en    = rst & pc_en_c;
  assign idex_flush = ~rst | flush_c;
  assign bubble_cnt = bcnt_q;
  assign err        = err_q;

`ifdef FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [2:0] rs, input stage_t m, input stage_t w);
    if (reg_match(rs, m, R0Z) && !m.wbsel) return FWD_MEM;
    if (reg_match(rs, w, R0Z)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_a = rst ? fwd_sel(ex_s.rs1, mem_s, wb_s) : FWD_RF;
  assign fwd_b = rst ? fwd_sel(ex_s.rs2, mem_s, wb_s) : FWD_RF;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  assign unused_fields = ^{ex_s, mem_s, wb_s};

endmodule
